// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: opcodes, funct codes, state encoding and ALU codes shared by the controller.
package multicycle_controller_pkg;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_t;
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fields in, datapath enables and mux selects out.
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       iord;
  logic       alusrca;
  logic       regdst;
  logic       memtoreg;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal_op;
  modport master (
    input  op, funct, zero,
    output pcen, memwrite, irwrite, regwrite, iord, alusrca, regdst, memtoreg,
           alusrcb, pcsrc, alucontrol, illegal_op
  );
  modport slave (
    output op, funct, zero,
    input  pcen, memwrite, irwrite, regwrite, iord, alusrca, regdst, memtoreg,
           alusrcb, pcsrc, alucontrol, illegal_op
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: maps aluop and R-type funct to the ALU operation code.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  aluop_t     i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol
);
  logic [2:0] w_fn;
  assign w_fn = (i_funct == F_ADD) ? ALU_ADD :
                (i_funct == F_SUB) ? ALU_SUB :
                (i_funct == F_AND) ? ALU_AND :
                (i_funct == F_OR)  ? ALU_OR  :
                (i_funct == F_SLT) ? ALU_SLT : ALU_ADD;
  assign o_alucontrol = (i_aluop == ALUOP_SUB)   ? ALU_SUB :
                        (i_aluop == ALUOP_FUNCT) ? w_fn    : ALU_ADD;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle MIPS datapath, one state per cycle.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input logic clk,
  input logic rst,
  multicycle_controller_if.master bus
);
  state_t r_state, w_next;
  aluop_t w_aluop;
  logic   w_pcwrite, w_branch, w_irwrite, w_memwrite, w_regwrite, w_illegal;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  always_comb begin
    w_next       = S_FETCH;
    w_aluop      = ALUOP_ADD;
    w_pcwrite    = 1'b0;
    w_branch     = 1'b0;
    w_irwrite    = 1'b0;
    w_memwrite   = 1'b0;
    w_regwrite   = 1'b0;
    w_illegal    = 1'b0;
    bus.iord     = 1'b0;
    bus.alusrca  = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_next      = S_DECODE;
        w_irwrite   = 1'b1;
        w_pcwrite   = 1'b1;
        bus.alusrcb = 2'b01;
      end
      S_DECODE: begin
        bus.alusrcb = 2'b11;
        w_next = (bus.op == OP_LW || bus.op == OP_SW) ? S_MEMADR  :
                 (bus.op == OP_RTYPE)                 ? S_EXECUTE :
                 (bus.op == OP_BEQ)                   ? S_BRANCH  :
                 (bus.op == OP_ADDI)                  ? S_ADDIEX  :
                 (bus.op == OP_J)                     ? S_JUMP    : S_FETCH;
        w_illegal = (w_next == S_FETCH);
      end
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        w_next      = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.iord = 1'b1;
        w_next   = S_MEMWB;
      end
      S_MEMWB: begin
        bus.memtoreg = 1'b1;
        w_regwrite   = 1'b1;
      end
      S_MEMWR: begin
        bus.iord   = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        bus.alusrca = 1'b1;
        w_aluop     = ALUOP_FUNCT;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        bus.regdst = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        bus.alusrca = 1'b1;
        bus.pcsrc   = 2'b01;
        w_aluop     = ALUOP_SUB;
        w_branch    = 1'b1;
      end
      S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        w_next      = S_ADDIWB;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JUMP: begin
        bus.pcsrc = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end
  // Enables are masked by rst so FETCH's writes stay quiet while reset holds the state there.
  assign bus.pcen       = rst & (w_pcwrite | (w_branch & bus.zero));
  assign bus.irwrite    = rst & w_irwrite;
  assign bus.memwrite   = rst & w_memwrite;
  assign bus.regwrite   = rst & w_regwrite;
  assign bus.illegal_op = rst & w_illegal;
  alu_decoder u_alu_decoder (
    .i_aluop      (w_aluop),
    .i_funct      (bus.funct),
    .o_alucontrol (bus.alucontrol)
  );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized instruction stream checked against an instruction-level model.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic [5:0] m_op = 6'b0;
  int m_k = 0;
  logic [15:0] obs;
  logic [5:0] fcodes [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  multicycle_controller_if bus();
  multicycle_controller dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign obs = {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.iord, bus.alusrca,
                bus.regdst, bus.memtoreg, bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.illegal_op};

  function automatic int cpi(input logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected output vector for cycle k (0 = FETCH) of instruction o.
  function automatic logic [15:0] expect_out(input logic [5:0] o, input logic [5:0] f,
                                             input logic z, input int k);
    logic pcen, mw, irw, rw, iord, asa, rd, mtr, ill;
    logic [1:0] asb, psrc;
    logic [2:0] ac;
    {pcen, mw, irw, rw, iord, asa, rd, mtr, ill} = '0;
    asb = 2'b00; psrc = 2'b00; ac = 3'b010;
    if (k == 0) begin irw = 1'b1; pcen = 1'b1; asb = 2'b01; end
    else if (k == 1) begin asb = 2'b11; ill = (cpi(o) == 2); end
    else if (o == 6'b100011 || o == 6'b101011) begin
      if (k == 2) begin asa = 1'b1; asb = 2'b10; end
      else if (o == 6'b101011) begin iord = 1'b1; mw = 1'b1; end
      else if (k == 3) iord = 1'b1;
      else begin mtr = 1'b1; rw = 1'b1; end
    end else if (o == 6'b000000) begin
      if (k == 2) begin asa = 1'b1; ac = alu_of(f); end
      else begin rd = 1'b1; rw = 1'b1; end
    end else if (o == 6'b000100) begin
      asa = 1'b1; ac = 3'b110; psrc = 2'b01; pcen = z;
    end else if (o == 6'b001000) begin
      if (k == 2) begin asa = 1'b1; asb = 2'b10; end
      else rw = 1'b1;
    end else if (o == 6'b000010) begin
      psrc = 2'b10; pcen = 1'b1;
    end
    return {pcen, mw, irw, rw, iord, asa, rd, mtr, asb, psrc, ac, ill};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h (op=%b k=%0d)", name, $time, act, exp, m_op, m_k);
    end
  endtask

  always @(negedge clk)
    if (chk_en) begin
      #2;
      check("model", obs, expect_out(m_op, bus.funct, bus.zero, m_k));
    end

  // op is only meaningful in DECODE/MEMADR; elsewhere it is scrambled to show it is ignored.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] fn);
    for (int k = 0; k < cpi(o); k++) begin
      @(negedge clk);
      m_op = o;
      m_k = k;
      bus.op = (k == 1 || k == 2) ? o : 6'($urandom);
      bus.funct = (k == 2) ? fn : fcodes[$urandom_range(0, 4)];
      bus.zero = 1'($urandom);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] lw_seq [5] = '{16'hA044, 16'h00C4, 16'h0484, 16'h0804, 16'h1104};
    logic [5:0] o, fn;
    bus.op = 6'b100011;
    bus.funct = 6'b0;
    bus.zero = 1'b0;
    #195;
    check("reset_hold", obs, 16'h0044);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      m_k = k;
      #2;
      check($sformatf("lw_cycle%0d", k + 1), obs, lw_seq[k]);
    end
    chk_en = 1'b1;
    run_instr(6'b100011, 6'b0);
    run_instr(6'b101011, 6'b0);
    for (int i = 0; i < 5; i++) run_instr(6'b000000, fcodes[i]);
    for (int i = 0; i < 4; i++) run_instr(6'b000100, 6'b0);
    run_instr(6'b001000, 6'b0);
    run_instr(6'b000010, 6'b0);
    run_instr(6'b111111, 6'b0);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 6) == 6) begin
        o = 6'($urandom);
        if (cpi(o) != 2) o = 6'b111111;
      end else o = ops[$urandom_range(0, 5)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fcodes[$urandom_range(0, 4)];
      run_instr(o, fn);
    end
    chk_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m_op = 6'b101011;
      m_k = k;
      bus.op = 6'b101011;
    end
    #2;
    check("memwr_before_rst", {15'b0, bus.memwrite}, 16'h0001);
    #1 rst = 1'b0;
    #1;
    check("memwrite_async_drop", {15'b0, bus.memwrite}, 16'h0000);
    check("async_rst_outputs", obs, 16'h0044);
    @(negedge clk);
    #2;
    check("rst_held_no_writes", obs, 16'h0044);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("fetch_after_release", obs, 16'hA044);
    @(negedge clk);
    #2;
    check("decode_after_release", obs, 16'h00C4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
